// File: rtl/ext_pkg.sv
// Shared constants for the P7 extension stage: mode encodings,
// default widths and handshake state encodings.
package ext_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IMM_W  = 16;

  localparam logic [2:0] EXT_ZERO = 3'd0;
  localparam logic [2:0] EXT_SIGN = 3'd1;
  localparam logic [2:0] EXT_LUI  = 3'd2;
  localparam logic [2:0] EXT_LB   = 3'd3;
  localparam logic [2:0] EXT_LBU  = 3'd4;
  localparam logic [2:0] EXT_LH   = 3'd5;
  localparam logic [2:0] EXT_LHU  = 3'd6;
  localparam logic [2:0] EXT_WORD = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/ext_core.sv
// Purely combinational extender: selects the byte/halfword lane or the
// immediate field according to the mode and widens it to DATA_W bits,
// also flagging misaligned halfword and word accesses.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] ext_data,
  output logic              ext_err
);

  logic [IMM_W-1:0] imm;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;

  // Lane selection; the halfword lane ignores off[0] so a misaligned
  // halfword still returns the aligned halfword containing it.
  always_comb begin
    imm       = data[IMM_W-1:0];
    byte_lane = data[{off, 3'b000} +: 8];
    half_lane = data[{off[OFF_W-1:1], 4'b0000} +: 16];
  end

  // Mode decode into the widened result and the misalignment flag.
  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (mode)
      EXT_ZERO: ext_data = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_SIGN: ext_data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_LUI:  ext_data = {imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_LB:   ext_data = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      EXT_LBU:  ext_data = {{(DATA_W-8){1'b0}}, byte_lane};
      EXT_LH: begin
        ext_data = {{(DATA_W-16){half_lane[15]}}, half_lane};
        ext_err  = off[0];
      end
      EXT_LHU: begin
        ext_data = {{(DATA_W-16){1'b0}}, half_lane};
        ext_err  = off[0];
      end
      EXT_WORD: begin
        ext_data = data;
        ext_err  = (off != '0);
      end
      default: begin
        ext_data = '0;
        ext_err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered extension stage: one main output register backed by a
// one-entry skid register, with valid/ready handshakes on both sides
// and a flush that discards everything held.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMM_W  = DEF_IMM_W,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  state_t            state;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;
  logic [DATA_W-1:0] core_data;
  logic              core_err;
  logic              accept;
  logic              drain;

  ext_core #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W),
    .OFF_W (OFF_W)
  ) u_core (
    .mode    (in_mode),
    .data    (in_data),
    .off     (in_off),
    .ext_data(core_data),
    .ext_err (core_err)
  );

  // Handshake qualifiers use only registered ready/valid, so there is
  // no combinational path from out_ready to in_ready.
  always_comb begin
    accept = in_valid & in_ready;
    drain  = out_valid & out_ready;
  end

  // Occupancy state machine; in_ready and out_valid are registered
  // copies of the next state so they never depend on same-cycle inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= core_data;
            out_err   <= core_err;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            out_data <= core_data;
            out_err  <= core_err;
          end else if (accept) begin
            skid_data <= core_data;
            skid_err  <= core_err;
            in_ready  <= 1'b0;
            state     <= TWO;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            out_data <= skid_data;
            out_err  <= skid_err;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: a table of single-transfer vectors
// for every mode, then hand-written stall, flush and reset sequences.
module tb_ext_pipe;
  import ext_pkg::*;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] data;
    logic [1:0]  off;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [31:0] in_data;
  logic [1:0]  in_off;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int passed = 0;
  int total  = 0;

  vec_t        vecs[13];
  logic [31:0] items[4];
  logic [31:0] received[$];

  ext_pipe #(.DATA_W(32), .IMM_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .in_off   (in_off),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] m, input logic [31:0] d,
                                input logic [1:0] o);
    in_valid = v;
    in_mode  = m;
    in_data  = d;
    in_off   = o;
  endtask

  // Push two items with out_ready low so both main and skid are full
  task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
    out_ready = 1'b0;
    apply_stimulus(1'b1, EXT_WORD, a, 2'd1);
    step();
    apply_stimulus(1'b1, EXT_WORD, b, 2'd1);
    step();
    check_output("fill_in_ready_low", {31'd0, in_ready}, 32'd0);
    check_output("fill_main_first", out_data, a);
  endtask

  initial begin
    bit fire_out;
    logic [31:0] cur_out;
    int next_in;
    int cyc;

    vecs[0]  = '{EXT_ZERO, 32'h0000_8001, 2'd0, 32'h0000_8001, 1'b0};
    vecs[1]  = '{EXT_SIGN, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0};
    vecs[2]  = '{EXT_LUI,  32'h0000_8001, 2'd0, 32'h8001_0000, 1'b0};
    vecs[3]  = '{EXT_LB,   32'h80FF_7F01, 2'd3, 32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{EXT_LBU,  32'h80FF_7F01, 2'd1, 32'h0000_007F, 1'b0};
    vecs[5]  = '{EXT_LH,   32'h80FF_7F01, 2'd2, 32'hFFFF_80FF, 1'b0};
    vecs[6]  = '{EXT_LHU,  32'h80FF_7F01, 2'd0, 32'h0000_7F01, 1'b0};
    vecs[7]  = '{EXT_LH,   32'h80FF_7F01, 2'd1, 32'h0000_7F01, 1'b1};
    vecs[8]  = '{EXT_WORD, 32'hDEAD_BEEF, 2'd2, 32'hDEAD_BEEF, 1'b1};
    vecs[9]  = '{EXT_WORD, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{EXT_LB,   32'h80FF_7F01, 2'd0, 32'h0000_0001, 1'b0};
    vecs[11] = '{EXT_LHU,  32'h80FF_7F01, 2'd3, 32'h0000_80FF, 1'b1};
    vecs[12] = '{EXT_ZERO, 32'hFFFF_1234, 2'd0, 32'h0000_1234, 1'b0};

    items[0] = 32'h1111_0001;
    items[1] = 32'h2222_0002;
    items[2] = 32'h3333_0003;
    items[3] = 32'h4444_0004;

    // Reset state
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, EXT_ZERO, 32'h0, 2'd0);
    step();
    step();
    reset = 1'b0;
    check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("reset_out_data", out_data, 32'd0);
    check_output("reset_out_err", {31'd0, out_err}, 32'd0);

    // Vector table streamed back to back with out_ready high
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(1'b1, vecs[i].mode, vecs[i].data, vecs[i].off);
      step();
      check_output($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_output($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      check_output($sformatf("vec%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
    end
    apply_stimulus(1'b0, EXT_ZERO, 32'h0, 2'd0);
    step();
    check_output("drain_empty", {31'd0, out_valid}, 32'd0);

    // Four back-to-back items with out_ready low for the first 3 cycles
    next_in = 0;
    received.delete();
    for (cyc = 0; cyc < 20 && received.size() < 4; cyc++) begin
      out_ready = (cyc >= 3);
      if (next_in < 4) apply_stimulus(1'b1, EXT_WORD, items[next_in], 2'd0);
      else apply_stimulus(1'b0, EXT_WORD, 32'h0, 2'd0);
      fire_out = out_valid && out_ready;
      cur_out  = out_data;
      if (in_valid && in_ready) next_in++;
      step();
      if (fire_out) received.push_back(cur_out);
      if (cyc == 1) check_output("stall_in_ready_drop", {31'd0, in_ready}, 32'd0);
      if (cyc >= 0 && cyc <= 2) check_output($sformatf("stall_hold%0d", cyc), out_data, items[0]);
    end
    check_output("stream_count", received.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < received.size()) check_output($sformatf("stream_item%0d", i), received[i], items[i]);
    end
    apply_stimulus(1'b0, EXT_ZERO, 32'h0, 2'd0);
    step();
    check_output("stream_no_dup", {31'd0, out_valid}, 32'd0);

    // Flush while full, with a third item offered in the same cycle
    fill_two(32'hAAAA_0001, 32'hAAAA_0002);
    apply_stimulus(1'b1, EXT_WORD, 32'hAAAA_0003, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    apply_stimulus(1'b0, EXT_ZERO, 32'h0, 2'd0);
    check_output("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_output($sformatf("flush_no_emit%0d", i), {31'd0, out_valid}, 32'd0);
    end

    // Reset while full
    fill_two(32'hBBBB_0001, 32'hBBBB_0002);
    check_output("prereset_err", {31'd0, out_err}, 32'd1);
    apply_stimulus(1'b0, EXT_ZERO, 32'h0, 2'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("midreset_out_data", out_data, 32'd0);
    check_output("midreset_out_err", {31'd0, out_err}, 32'd0);

    // Resume with a single transfer
    out_ready = 1'b1;
    apply_stimulus(1'b1, EXT_ZERO, 32'h0000_1234, 2'd0);
    step();
    apply_stimulus(1'b0, EXT_ZERO, 32'h0, 2'd0);
    check_output("resume_valid", {31'd0, out_valid}, 32'd1);
    check_output("resume_data", out_data, 32'h0000_1234);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output($sformatf("resume_quiet%0d", i), {31'd0, out_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
